// File: rtl/prio_arbiter_rr_amisha_pkg.sv
// Shared types and helpers for the priority / round-robin arbiter slice.
// Holds the FSM state enum and a constant-foldable ceil(log2) helper.
package prio_arbiter_rr_amisha_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // ceil(log2(value)), never less than 1 so it can size a vector directly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/prio_pick_amisha.sv
// Combinational winner search: first set request found scanning downward
// from start_i, wrapping from index 0 back to N-1.
module prio_pick_amisha
  import prio_arbiter_rr_amisha_pkg::*;
#(
  parameter int N  = 8,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] start_i,
  output logic          found_o,
  output logic [PW-1:0] idx_o
);

  // Scan from the farthest offset to the nearest so the nearest hit is the
  // last assignment and therefore wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int pos;
      pos = int'(start_i) - k;
      if (pos < 0) pos = pos + N;
      if (req_i[PW'(pos)]) begin
        found_o = 1'b1;
        idx_o   = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/prio_arbiter_rr_amisha.sv
// Fixed-priority or round-robin arbiter with registered one-hot grant,
// index+1 code, ack-based release and hold-time revocation.
module prio_arbiter_rr_amisha
  import prio_arbiter_rr_amisha_pkg::*;
#(
  parameter int N        = 8,
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 15,
  localparam int W       = clog2(N + 1)
) (
  input  logic         clk_amisha,
  input  logic         rst_n_amisha,
  input  logic [N-1:0] req_amisha,
  input  logic         ack_amisha,
  output logic [N-1:0] grant_amisha,
  output logic [W-1:0] code_amisha,
  output logic         valid_amisha,
  output logic         timeout_amisha
);

  localparam int PW = clog2(N);

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [W-1:0]  code_q, code_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    hold_cnt_q, hold_cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;

  logic          pick_found;
  logic [PW-1:0] pick_idx, pick_start, winner_idx;
  logic          hit_max, release_now;

  // Fixed priority is just a downward search that always starts at the top.
  assign pick_start  = (MODE == 0) ? PW'(N - 1) : ptr_q;
  assign winner_idx  = PW'(code_q - W'(1));
  assign hit_max     = (hold_cnt_q == 8'(MAX_HOLD));
  assign release_now = ack_amisha || hit_max;

  prio_pick_amisha #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req_i   (req_amisha),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
      ptr_q      <= PW'(N - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_found) state_d = GRANT;
      GRANT:   if (release_now) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d    = grant_q;
    code_d     = code_q;
    valid_d    = valid_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = N'(1) << pick_idx;
          code_d     = W'(pick_idx) + W'(1);
          valid_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          grant_d   = '0;
          code_d    = '0;
          valid_d   = 1'b0;
          // Ack on the limit cycle counts as a normal release.
          timeout_d = !ack_amisha;
          if (MODE == 1) begin
            ptr_d = (winner_idx == '0) ? PW'(N - 1) : winner_idx - PW'(1);
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign grant_amisha   = grant_q;
  assign code_amisha    = code_q;
  assign valid_amisha   = valid_q;
  assign timeout_amisha = timeout_q;

endmodule

// File: tb/tb_prio_arbiter_rr_amisha.sv
// Scoreboard bench: a fixed-priority N=8 arbiter and a round-robin N=4
// arbiter, both MAX_HOLD=3, checked every cycle against a behavioural model.
module tb_prio_arbiter_rr_amisha;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [7:0] req0 = '0;
  logic       ack0 = 1'b0;
  logic [7:0] grant0;
  logic [3:0] code0;
  logic       valid0, tout0;
  logic [3:0] req1 = '0;
  logic       ack1 = 1'b0;
  logic [3:0] grant1;
  logic [2:0] code1;
  logic       valid1, tout1;

  prio_arbiter_rr_amisha #(.N(8), .MODE(0), .MAX_HOLD(3)) dut0 (
    .clk_amisha     (clk),
    .rst_n_amisha   (rst_n),
    .req_amisha     (req0),
    .ack_amisha     (ack0),
    .grant_amisha   (grant0),
    .code_amisha    (code0),
    .valid_amisha   (valid0),
    .timeout_amisha (tout0)
  );

  prio_arbiter_rr_amisha #(.N(4), .MODE(1), .MAX_HOLD(3)) dut1 (
    .clk_amisha     (clk),
    .rst_n_amisha   (rst_n),
    .req_amisha     (req1),
    .ack_amisha     (ack1),
    .grant_amisha   (grant1),
    .code_amisha    (code1),
    .valid_amisha   (valid1),
    .timeout_amisha (tout1)
  );

  // Model: who holds the resource, for how long, and where the next
  // round-robin search begins.
  typedef struct {
    bit busy;
    int winner;
    int age;
    int next_start;
    bit tout;
  } model_t;

  typedef struct {
    logic [31:0] grant;
    int          code;
    bit          valid;
    bit          tout;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  model_t m0, m1;
  int     n_checks = 0;
  int     n_pass   = 0;

  function automatic model_t fresh_model(input int n);
    model_t m;
    m.busy = 1'b0; m.winner = 0; m.age = 0; m.next_start = n - 1; m.tout = 1'b0;
    return m;
  endfunction

  function automatic int choose(input model_t m, input int n, input int mode,
                                input logic [31:0] req);
    if (mode == 0) begin
      for (int i = n - 1; i >= 0; i--) if (req[i]) return i;
    end else begin
      for (int k = 0; k < n; k++) begin
        int i;
        i = (m.next_start - k + n) % n;
        if (req[i]) return i;
      end
    end
    return -1;
  endfunction

  function automatic model_t step(input model_t m, input int n, input int mode,
                                  input int maxh, input logic [31:0] req, input bit ack);
    model_t r;
    int w;
    r = m;
    r.tout = 1'b0;
    if (!m.busy) begin
      w = choose(m, n, mode, req);
      if (w >= 0) begin
        r.busy = 1'b1; r.winner = w; r.age = 0;
      end
    end else if (ack || m.age == maxh) begin
      r.busy = 1'b0;
      r.tout = !ack;
      if (mode == 1) r.next_start = (m.winner + n - 1) % n;
    end else begin
      r.age = m.age + 1;
    end
    return r;
  endfunction

  function automatic exp_t expect_of(input model_t m);
    exp_t e;
    e.grant = m.busy ? (32'd1 << m.winner) : 32'd0;
    e.code  = m.busy ? m.winner + 1 : 0;
    e.valid = m.busy;
    e.tout  = m.tout;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " grant0"}, 32'(grant0), 32'd0);
    check({tag, " code0"},  32'(code0),  32'd0);
    check({tag, " valid0"}, 32'(valid0), 32'd0);
    check({tag, " tout0"},  32'(tout0),  32'd0);
    check({tag, " grant1"}, 32'(grant1), 32'd0);
    check({tag, " code1"},  32'(code1),  32'd0);
    check({tag, " valid1"}, 32'(valid1), 32'd0);
    check({tag, " tout1"},  32'(tout1),  32'd0);
  endtask

  // Called just after a falling edge: applies inputs and queues what the
  // outputs must be once the next rising edge has sampled them.
  task automatic drive(input logic [7:0] r0, input bit a0, input logic [3:0] r1, input bit a1);
    req0 = r0; ack0 = a0; req1 = r1; ack1 = a1;
    m0 = step(m0, 8, 0, 3, 32'(r0), a0);
    m1 = step(m1, 4, 1, 3, 32'(r1), a1);
    q0.push_back(expect_of(m0));
    q1.push_back(expect_of(m1));
    $display("txn t=%0t req0=%02h ack0=%0b req1=%h ack1=%0b exp_code0=%0d exp_code1=%0d",
             $time, r0, a0, r1, a1, expect_of(m0).code, expect_of(m1).code);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        exp_t e;
        e = q0.pop_front();
        check("d0 grant", 32'(grant0), e.grant);
        check("d0 code",  32'(code0),  32'(e.code));
        check("d0 valid", 32'(valid0), 32'(e.valid));
        check("d0 tout",  32'(tout0),  32'(e.tout));
      end
      if (q1.size() > 0) begin
        exp_t e;
        e = q1.pop_front();
        check("d1 grant", 32'(grant1), e.grant);
        check("d1 code",  32'(code1),  32'(e.code));
        check("d1 valid", 32'(valid1), 32'(e.valid));
        check("d1 tout",  32'(tout1),  32'(e.tout));
      end
    end
  end

  initial begin
    m0 = fresh_model(8);
    m1 = fresh_model(4);
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h00, 1'b0, 4'h0, 1'b0);

    // Fixed-priority pick of 0x26 while round-robin cycles with constant ack.
    @(negedge clk); drive(8'h26, 1'b0, 4'hF, 1'b1);
    @(negedge clk); drive(8'h00, 1'b1, 4'hF, 1'b1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); drive(8'h00, 1'b0, 4'hF, 1'b1);
    end

    // Unacknowledged grants run into the hold limit.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); drive(8'h81, 1'b0, 4'h2, 1'b0);
    end
    // Ack lands exactly on the limit cycle.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(8'h81, m0.busy && m0.age == 3, 4'h6, m1.busy && m1.age == 3);
    end

    // Winner drops its request while granted.
    @(negedge clk); drive(8'h00, 1'b1, 4'h0, 1'b1);
    @(negedge clk); drive(8'h10, 1'b0, 4'h4, 1'b0);
    @(negedge clk); drive(8'h00, 1'b0, 4'h0, 1'b0);
    @(negedge clk); drive(8'h00, 1'b0, 4'h0, 1'b0);
    @(negedge clk); drive(8'h00, 1'b1, 4'h0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      logic [7:0] r0;
      logic [3:0] r1;
      r0 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      @(negedge clk);
      drive(r0, $urandom_range(0, 3) == 0, r1, $urandom_range(0, 3) == 0);
    end

    // Quiet requests with random ack.
    @(negedge clk); drive(8'h00, 1'b1, 4'h0, 1'b1);
    @(negedge clk); drive(8'h00, 1'b1, 4'h0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); drive(8'h00, 1'($urandom), 4'h0, 1'($urandom));
    end

    // Asynchronous reset in the middle of a grant.
    @(negedge clk); drive(8'h03, 1'b0, 4'h1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    m0 = fresh_model(8);
    m1 = fresh_model(4);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h00, 1'b0, 4'hF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive(8'h0C, 1'b1, 4'hF, 1'b1);
    end

    @(negedge clk);
    @(negedge clk);
    check("queue0 drained", 32'(q0.size()), 32'd0);
    check("queue1 drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
